// File: rtl/bridge_unpack_if.sv
// Stream bundle around bridge_unpack: an M-bit upstream side and an N-bit downstream side.
// The slave modport is the bridge's view; master is the environment driving both ends.
interface bridge_unpack_if #(
   parameter int M = 128,
   parameter int N = 48
);
   logic         vld_i;
   logic [M-1:0] din;
   logic         last_i;
   logic         rdy_o;
   logic         vld_o;
   logic [N-1:0] dout;
   logic         last_o;
   logic         rdy_i;

   modport slave (
      input  vld_i, din, last_i, rdy_i,
      output rdy_o, vld_o, dout, last_o
   );

   modport master (
      output vld_i, din, last_i, rdy_i,
      input  rdy_o, vld_o, dout, last_o
   );
endinterface

// File: rtl/bridge_unpack.sv
// Width converter: splits M-bit words into N-bit words, MSB first, packet-aware.
// A left-aligned residue buffer holds pending bits; a partial final word is zero-padded.
module bridge_unpack #(
   parameter int M = 128,
   parameter int N = 48
) (
   input logic            clk,
   input logic            rst_n,
   bridge_unpack_if.slave bus
);
   localparam int BUF_W = M + N - 1;
   localparam int CNT_W = $clog2(M + N);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] READY = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   generate
      if (M <= N) begin : g_param_check
         $error("bridge_unpack: M must be greater than N");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [BUF_W-1:0] buf_q, buf_d, buf_after, din_aligned;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_after;
   logic             last_pend_q, last_pend_d;
   logic             vld, last, rdy, push, pop, flush;

   assign vld   = (state_q == READY) || (state_q == DRAIN);
   assign last  = vld && last_pend_q && (cnt_q <= CNT_W'(N));
   assign pop   = vld && bus.rdy_i;
   assign flush = pop && ((state_q == DRAIN) || last);
   assign rdy   = !last_pend_q && (cnt_after < CNT_W'(N));
   assign push  = bus.vld_i && rdy;

   // New word lands directly below the bits that survive this cycle's pop.
   assign din_aligned = {bus.din, {(N-1){1'b0}}} >> cnt_after;

   always_comb begin
      buf_after = buf_q;
      cnt_after = cnt_q;
      if (flush) begin
         buf_after = '0;
         cnt_after = '0;
      end else if (pop) begin
         buf_after = buf_q << N;
         cnt_after = cnt_q - CNT_W'(N);
      end
   end

   always_comb begin
      buf_d       = buf_after;
      cnt_d       = cnt_after;
      last_pend_d = last_pend_q && !flush;
      if (push) begin
         buf_d       = buf_after | din_aligned;
         cnt_d       = cnt_after + CNT_W'(M);
         last_pend_d = last_pend_d || bus.last_i;
      end
   end

   always_comb begin
      state_d = FILL;
      if (cnt_d == '0)
         state_d = EMPTY;
      else if (cnt_d >= CNT_W'(N))
         state_d = READY;
      else if (last_pend_d)
         state_d = DRAIN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         buf_q       <= '0;
         cnt_q       <= '0;
         last_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         last_pend_q <= last_pend_d;
      end
   end

   assign bus.rdy_o  = rdy;
   assign bus.vld_o  = vld;
   assign bus.dout   = buf_q[BUF_W-1 -: N];
   assign bus.last_o = last;
endmodule
